// File: rtl/sprite_fetch_seq.sv
// Sprite pattern-address generator: tests whether a sprite covers the current scanline,
// then issues one VRAM pattern address per horizontal tile over a valid/ready handshake.
`timescale 1ns/1ps
module sprite_fetch_seq #(
  parameter int TC_W   = 5,
  parameter int ROW_W  = 3,
  parameter int Y_W    = 8,
  parameter int SIZE_W = 2,
  localparam int ADDR_W = 2*TC_W + ROW_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2*TC_W-1:0] req_tile,
  input  logic [Y_W-1:0]    req_y,
  input  logic [SIZE_W-1:0] req_h,
  input  logic [SIZE_W-1:0] req_w,
  input  logic              req_x_mirror,
  input  logic              req_y_mirror,
  input  logic [Y_W-1:0]    req_row,
  input  logic              abort,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [SIZE_W-1:0] addr_slot,
  output logic              addr_last,
  output logic              done,
  output logic              done_hit
);

  localparam int RI_W  = SIZE_W + ROW_W;
  localparam int LIM_W = SIZE_W + 1 + ROW_W;
  localparam int CMP_W = (Y_W > LIM_W) ? Y_W : LIM_W;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [2*TC_W-1:0]   r_tile;
  logic [Y_W-1:0]      r_y, r_row;
  logic [SIZE_W-1:0]   r_h, r_w, r_k;
  logic                r_xm, r_ym, r_hit;
  logic [RI_W-1:0]     r_ri;

  logic                w_accept, w_issue, w_last, w_fire, w_hit;
  logic [Y_W-1:0]      w_off;
  logic [SIZE_W:0]     w_h1;
  logic [LIM_W-1:0]    w_lim;
  logic [CMP_W-1:0]    w_off_x, w_lim_x, w_ri_x;
  logic [RI_W-1:0]     w_ri;
  logic [TC_W-1:0]     w_ty, w_tx;

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_valid && req_ready && !abort;
  assign w_issue   = (r_state == S_ISSUE);
  assign w_last    = (r_k == r_w);
  assign w_fire    = w_issue && addr_ready;

  // Row-coverage test; the offset wraps mod 2^Y_W so sprites straddling row 0 still hit.
  assign w_off   = r_row - r_y;
  assign w_h1    = {1'b0, r_h} + (SIZE_W+1)'(1);
  assign w_lim   = {w_h1, {ROW_W{1'b0}}};
  assign w_off_x = CMP_W'(w_off);
  assign w_lim_x = CMP_W'(w_lim);
  assign w_hit   = (w_off_x < w_lim_x);
  assign w_ri_x  = r_ym ? (w_lim_x - w_off_x - CMP_W'(1)) : w_off_x;
  assign w_ri    = w_ri_x[RI_W-1:0];

  // Each coordinate wraps independently; tx never carries into ty.
  assign w_ty = r_tile[2*TC_W-1:TC_W] + TC_W'(r_ri[RI_W-1:ROW_W]);
  assign w_tx = r_tile[TC_W-1:0] + TC_W'(r_k);

  assign addr_valid = w_issue;
  assign addr       = w_issue ? {w_ty, w_tx, r_ri[ROW_W-1:0]} : '0;
  assign addr_slot  = w_issue ? (r_xm ? (r_w - r_k) : r_k) : '0;
  assign addr_last  = w_issue && w_last;
  assign done       = (r_state == S_DONE);
  assign done_hit   = done && r_hit;

  always_comb begin
    // NOTE: default assigned first so every path drives w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = S_CALC;
      S_CALC:  w_next = w_hit ? S_ISSUE : S_DONE;
      S_ISSUE: if (addr_ready && w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tile <= '0;
      r_y    <= '0;
      r_row  <= '0;
      r_h    <= '0;
      r_w    <= '0;
      r_xm   <= 1'b0;
      r_ym   <= 1'b0;
      r_k    <= '0;
      r_ri   <= '0;
      r_hit  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tile <= req_tile;
        r_y    <= req_y;
        r_row  <= req_row;
        r_h    <= req_h;
        r_w    <= req_w;
        r_xm   <= req_x_mirror;
        r_ym   <= req_y_mirror;
        r_k    <= '0;
      end
      if (r_state == S_CALC) begin
        r_ri  <= w_ri;
        r_hit <= w_hit;
      end
      if (w_fire && !w_last) r_k <= r_k + SIZE_W'(1);
    end
  end

endmodule
